// File: rtl/platform_collision_pkg.sv
// ============================================================================
// platform_pkg : shared constants, types and landing test for platform_collision
// Rev 1.0
// ============================================================================
`default_nettype none

package platform_pkg;

    localparam int NUM_PLAT      = 8;
    localparam int PLAT_HALF_W   = 20;
    localparam int DOODLE_HALF_W = 10;
    localparam int DOODLE_SIZE   = 10;
    localparam int LAND_TOL      = 8;
    localparam int PLAT_H        = LAND_TOL;

    typedef logic        [9:0]  coord_t;
    typedef logic signed [9:0]  vel_t;
    typedef logic        [2:0]  idx_t;
    // One bit wider than needed for coordinates, so Y+offset sums never wrap.
    typedef logic signed [11:0] sarith_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic land_test(
        input coord_t px,
        input coord_t py,
        input coord_t dx,
        input coord_t dy,
        input vel_t   dv
    );
        sarith_t bottom;
        sarith_t top;
        sarith_t dxs;
        sarith_t adx;
        logic    falling;
        falling = (dv > vel_t'(0));
        bottom  = sarith_t'({2'b00, dy}) + sarith_t'(DOODLE_SIZE);
        top     = sarith_t'({2'b00, py});
        dxs     = sarith_t'({2'b00, dx}) - sarith_t'({2'b00, px});
        adx     = (dxs < sarith_t'(0)) ? -dxs : dxs;
        land_test = falling
                  && (bottom >= top)
                  && (bottom <= top + sarith_t'(LAND_TOL))
                  && (adx <= sarith_t'(PLAT_HALF_W + DOODLE_HALF_W));
    endfunction

endpackage

`default_nettype wire

// File: rtl/platform_collision_if.sv
// ============================================================================
// platform_collision_if : platform/doodle inputs and landing result bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface platform_collision_if;
    import platform_pkg::*;

    coord_t Platform_X_in [NUM_PLAT];
    coord_t Platform_Y_in [NUM_PLAT];
    coord_t Doodle_X;
    coord_t Doodle_Y;
    vel_t   Doodle_Y_Motion;

    logic   hit;
    idx_t   hit_idx;
    coord_t hit_Y;
    logic   done;
    logic   busy;
    logic   overrun;

    modport master (
        output Platform_X_in, Platform_Y_in, Doodle_X, Doodle_Y, Doodle_Y_Motion,
        input  hit, hit_idx, hit_Y, done, busy, overrun
    );

    modport slave (
        input  Platform_X_in, Platform_Y_in, Doodle_X, Doodle_Y, Doodle_Y_Motion,
        output hit, hit_idx, hit_Y, done, busy, overrun
    );

endinterface

`default_nettype wire

// File: rtl/platform_collision_frame_edge_sync.sv
// ============================================================================
// frame_edge_sync : 2-flop synchronizer plus registered rising-edge detect
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_edge_sync (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic async_i,
    output logic      rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/platform_collision.sv
// ============================================================================
// platform_collision : per-frame sequential scan of 8 platforms for a landing
// Rev 1.0
// ============================================================================
`default_nettype none

module platform_collision
    import platform_pkg::*;
(
    input  wire logic           Clk,
    input  wire logic           Reset,
    input  wire logic           frame_clk,
    platform_collision_if.slave bus
);

    localparam idx_t LAST_IDX = idx_t'(NUM_PLAT - 1);

    logic   frame_rise;
    state_t state_q;
    idx_t   idx_q;
    idx_t   idx_d;

    coord_t px_q [NUM_PLAT];
    coord_t py_q [NUM_PLAT];
    coord_t dx_q;
    coord_t dy_q;
    vel_t   dv_q;

    logic   acc_hit_q;
    idx_t   acc_idx_q;
    coord_t acc_y_q;

    logic   hit_q;
    idx_t   hit_idx_q;
    coord_t hit_y_q;
    logic   done_q;
    logic   busy_q;
    logic   overrun_q;

    frame_edge_sync u_sync (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .async_i (frame_clk),
        .rise_o  (frame_rise)
    );

    assign idx_d = idx_q + idx_t'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
            dx_q      <= '0;
            dy_q      <= '0;
            dv_q      <= '0;
            acc_hit_q <= 1'b0;
            acc_idx_q <= '0;
            acc_y_q   <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            hit_y_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A frame edge during a scan is dropped; only the flag records it.
            if (frame_rise && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (frame_rise) begin
                        state_q <= ST_SNAP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SNAP: begin
                    for (int i = 0; i < NUM_PLAT; i++) begin
                        px_q[i] <= bus.Platform_X_in[i];
                        py_q[i] <= bus.Platform_Y_in[i];
                    end
                    dx_q      <= bus.Doodle_X;
                    dy_q      <= bus.Doodle_Y;
                    dv_q      <= bus.Doodle_Y_Motion;
                    acc_hit_q <= 1'b0;
                    acc_idx_q <= '0;
                    acc_y_q   <= '0;
                    idx_q     <= '0;
                    state_q   <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (!acc_hit_q && land_test(px_q[idx_q], py_q[idx_q], dx_q, dy_q, dv_q)) begin
                        acc_hit_q <= 1'b1;
                        acc_idx_q <= idx_q;
                        acc_y_q   <= py_q[idx_q];
                    end
                    idx_q <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    hit_q     <= acc_hit_q;
                    hit_idx_q <= acc_idx_q;
                    hit_y_q   <= acc_y_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hit     = hit_q;
    assign bus.hit_idx = hit_idx_q;
    assign bus.hit_Y   = hit_y_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_platform_collision.sv
// ============================================================================
// tb_platform_collision : vector table + scoreboard bench for platform_collision
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_platform_collision;
    import platform_pkg::*;

    typedef struct {
        int dx;
        int dy;
        int dv;
        int exp_hit;
        int exp_idx;
        int exp_y;
    } vec_t;

    typedef struct {
        int hit;
        int idx;
        int y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic frame_clk;

    always #5 clk = ~clk;

    platform_collision_if bus ();

    platform_collision dut (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    int   px_tab [8] = '{140, 180, 220, 260, 300, 340, 380, 420};
    int   py_tab [8] = '{ 40,  80, 120, 160, 200, 240, 240, 230};
    vec_t vecs   [11];
    exp_t sb_q   [$];
    exp_t mon_e;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("hit",     int'(bus.hit),     mon_e.hit);
                check("hit_idx", int'(bus.hit_idx), mon_e.idx);
                check("hit_Y",   int'(bus.hit_Y),   mon_e.y);
            end
        end
    end

    task automatic set_doodle(input int dx, input int dy, input int dv);
        bus.Doodle_X        = coord_t'(dx);
        bus.Doodle_Y        = coord_t'(dy);
        bus.Doodle_Y_Motion = vel_t'(dv);
    endtask

    task automatic push_exp(input int h, input int idx, input int y);
        exp_t e;
        e.hit = h;
        e.idx = idx;
        e.y   = y;
        sb_q.push_back(e);
    endtask

    task automatic frame_pulse(input int hi_cycles);
        frame_clk = 1'b1;
        repeat (hi_cycles) @(posedge clk);
        #1 frame_clk = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int got;
        got = 0;
        for (int c = 0; c < 60 && got == 0; c++) begin
            @(posedge clk);
            #1;
            if (done_cnt != start) got = 1;
        end
        if (got == 0) check("done_timeout", 0, 1);
        else          check("done_width", int'(bus.done), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int start;
        set_doodle(v.dx, v.dy, v.dv);
        push_exp(v.exp_hit, v.exp_idx, v.exp_y);
        busy_cnt = 0;
        start    = done_cnt;
        frame_pulse(3);
        wait_done(start);
        check("busy_cycles", busy_cnt, 10);
        repeat (3) @(posedge clk);
        #1 check("hold_hit", int'(bus.hit), v.exp_hit);
    endtask

    initial begin
        int start;
        vecs = '{
            '{300, 192,  3, 1, 4, 200},
            '{300, 192, -3, 0, 0,   0},
            '{300, 192,  0, 0, 0,   0},
            '{360, 232,  2, 1, 5, 240},
            '{330, 190,  1, 1, 4, 200},
            '{331, 190,  1, 0, 0,   0},
            '{270, 190,  1, 1, 4, 200},
            '{269, 190,  1, 0, 0,   0},
            '{300, 198,  1, 1, 4, 200},
            '{300, 199,  1, 0, 0,   0},
            '{300, 189,  1, 0, 0,   0}
        };

        rst       = 1'b1;
        frame_clk = 1'b0;
        set_doodle(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            bus.Platform_X_in[i] = coord_t'(px_tab[i]);
            bus.Platform_Y_in[i] = coord_t'(py_tab[i]);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit",     int'(bus.hit),     0);
        check("rst_hit_idx", int'(bus.hit_idx), 0);
        check("rst_hit_Y",   int'(bus.hit_Y),   0);
        check("rst_done",    int'(bus.done),    0);
        check("rst_busy",    int'(bus.busy),    0);
        check("rst_overrun", int'(bus.overrun), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);
        check("overrun_idle", int'(bus.overrun), 0);

        // Doodle inputs change mid-scan: result must follow the snapshot.
        set_doodle(300, 192, 3);
        push_exp(1, 4, 200);
        start = done_cnt;
        frame_pulse(3);
        repeat (4) @(posedge clk);
        #1 set_doodle(0, 500, -5);
        bus.Platform_Y_in[4] = coord_t'(700);
        wait_done(start);
        bus.Platform_Y_in[4] = coord_t'(py_tab[4]);

        // Second frame edge four cycles after the first.
        set_doodle(360, 232, 2);
        push_exp(1, 5, 240);
        busy_cnt  = 0;
        start     = done_cnt;
        frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 frame_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 frame_clk = 1'b0;
        wait_done(start);
        repeat (30) @(posedge clk);
        #1;
        check("overrun_done_count", done_cnt - start, 1);
        check("overrun_busy_cycles", busy_cnt, 10);
        check("overrun_set", int'(bus.overrun), 1);
        run_vec(vecs[0]);
        check("overrun_sticky", int'(bus.overrun), 1);

        // Reset while scanning entry 3.
        set_doodle(300, 192, 3);
        start = done_cnt;
        frame_pulse(3);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_hit",     int'(bus.hit),     0);
        check("midrst_hit_idx", int'(bus.hit_idx), 0);
        check("midrst_hit_Y",   int'(bus.hit_Y),   0);
        check("midrst_busy",    int'(bus.busy),    0);
        check("midrst_overrun", int'(bus.overrun), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1 check("midrst_no_done", done_cnt - start, 0);
        run_vec(vecs[3]);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
